// File: rtl/serial_add4_ctrl.sv
// Four-operand unsigned adder: two-level bit-serial full-adder tree, LSB first.
// Latency: out_valid rises W+3 edges after the accepting edge (W+2 shift edges + 1 settle edge).
// Backpressure: accepts only when idle; holds q/ovf/out_valid until out_ready, then returns to idle.
//
// Ports:
//   clk, rst          - single clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready - request handshake carrying operands a, b, c, d (W bits each)
//   out_valid/out_ready - result handshake; q is the W+2-bit sum, ovf = sum exceeds W bits
//   busy              - high while the serial datapath is shifting
module serial_add4_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W+1:0] q,
  output logic         ovf,
  output logic         busy
);

  localparam int N  = W + 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N-1:0]  sa, sb, sc, sd;
  logic [N-1:0]  acc;
  logic          cy0, cy1, cy2;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          shift_en;
  logic          last;

  // Full-adder tree on the current LSBs.
  logic s0, s1, s2;
  logic co0, co1, co2;

  assign s0  = sa[0] ^ sb[0] ^ cy0;
  assign co0 = (sa[0] & sb[0]) | (sa[0] & cy0) | (sb[0] & cy0);
  assign s1  = sc[0] ^ sd[0] ^ cy1;
  assign co1 = (sc[0] & sd[0]) | (sc[0] & cy1) | (sd[0] & cy1);
  assign s2  = s0 ^ s1 ^ cy2;
  assign co2 = (s0 & s1) | (s0 & cy2) | (s1 & cy2);

  // The counter runs 0..N; at N all bits are shifted and the SHIFT state
  // spends one more edge handing the accumulator over to q.
  assign last     = (cnt == CW'(N));
  assign accept   = (state == IDLE) && in_valid;
  assign shift_en = (state == SHIFT) && !last;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sc    <= '0;
      sd    <= '0;
      acc   <= '0;
      cy0   <= 1'b0;
      cy1   <= 1'b0;
      cy2   <= 1'b0;
      cnt   <= '0;
      q     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sa  <= {2'b00, a};
        sb  <= {2'b00, b};
        sc  <= {2'b00, c};
        sd  <= {2'b00, d};
        cy0 <= 1'b0;
        cy1 <= 1'b0;
        cy2 <= 1'b0;
        cnt <= '0;
      end else if (shift_en) begin
        sa  <= {1'b0, sa[N-1:1]};
        sb  <= {1'b0, sb[N-1:1]};
        sc  <= {1'b0, sc[N-1:1]};
        sd  <= {1'b0, sd[N-1:1]};
        cy0 <= co0;
        cy1 <= co1;
        cy2 <= co2;
        acc <= {s2, acc[N-1:1]};
        cnt <= cnt + CW'(1);
      end
      // q only changes when a new result completes, so the previous result
      // stays visible through the idle and shifting phases.
      if ((state == SHIFT) && last) begin
        q <= acc;
      end
    end
  end

  assign ovf = |q[W+1:W];

endmodule

// File: tb/tb_serial_add4_ctrl.sv
module tb_serial_add4_ctrl;

  localparam int W = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b, c, d;
  logic         out_valid;
  logic         out_ready;
  logic [W+1:0] q;
  logic         ovf;
  logic         busy;

  int n_checks = 0;
  int n_err    = 0;

  serial_add4_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_sum(input int x0, input int x1, input int x2, input int x3);
    return x0 + x1 + x2 + x3;
  endfunction

  // Presents one request (DUT must be idle), returns edges until out_valid.
  task automatic run_req(input int x0, input int x1, input int x2, input int x3, output int lat);
    a = W'(x0); b = W'(x1); c = W'(x2); d = W'(x3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_q"}, q, 0);
    check({tag, "_ovf"}, ovf, 0);
  endtask

  // Global time limit so the run always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int e;
    int qexp[$];
    int acc_cyc;
    int cycle;
    int done_cnt;
    logic prev_ov;
    int v[4];

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    #17;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Basic sum and latency
    run_req(1, 2, 3, 4, lat);
    check("lat_1234", lat, 11);
    check("q_1234", q, 10);
    check("ovf_1234", ovf, 0);

    // Stall for 5 cycles: result must stay put
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_q", q, 10);
      check("stall_ovf", ovf, 0);
    end
    consume();
    check("retain_q", q, 10);

    // All-ones and all-zeros
    run_req(MAXV, MAXV, MAXV, MAXV, lat);
    check("lat_max", lat, 11);
    check("q_max", q, 1020);
    check("ovf_max", ovf, 1);
    consume();
    run_req(0, 0, 0, 0, lat);
    check("q_zero", q, 0);
    check("ovf_zero", ovf, 0);
    consume();

    // New request presented while shifting must be ignored
    a = 1; b = 2; c = 3; d = 4;
    in_valid = 1'b1;
    tick();
    a = 9; b = 9; c = 9; d = 9;
    lat = 0;
    while (!out_valid && lat < 50) begin
      check("shift_no_ready", in_ready, 0);
      tick();
      lat++;
    end
    check("ign_lat", lat, 11);
    check("ign_q", q, 10);
    tick();
    check("ign_done_hold", out_valid, 1);
    in_valid = 1'b0;
    consume();
    run_req(9, 9, 9, 9, lat);
    check("q_9999", q, 36);
    consume();

    // Reset in the middle of shifting, then a clean request
    a = 200; b = 100; c = 50; d = 25;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_abort_busy", busy, 1);
    rst = 1'b0;
    #2;
    check_reset_state("abort");
    @(negedge clk);
    rst = 1'b1;
    tick();
    run_req(7, 7, 7, 7, lat);
    check("lat_7777", lat, 11);
    check("q_7777", q, 28);
    check("ovf_7777", ovf, 0);
    consume();

    // Random back-to-back traffic with output stalls
    cycle = 0;
    done_cnt = 0;
    acc_cyc = 0;
    prev_ov = 1'b0;
    while (done_cnt < 1000 && cycle < 60000) begin
      @(posedge clk);
      #1;
      cycle++;
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0: v[k] = 0;
          1: v[k] = MAXV;
          default: v[k] = int'($urandom_range(0, MAXV));
        endcase
      end
      a = W'(v[0]); b = W'(v[1]); c = W'(v[2]); d = W'(v[3]);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      check("rnd_ready_busy", in_ready & busy, 0);
      if (in_valid && in_ready) begin
        qexp.push_back(ref_sum(v[0], v[1], v[2], v[3]));
        acc_cyc = cycle + 1;
      end
      if (out_valid && !prev_ov) check("rnd_lat", cycle - acc_cyc, 11);
      prev_ov = out_valid;
      if (out_valid) begin
        if (qexp.size() == 0) begin
          check("rnd_spurious_valid", out_valid, 0);
        end else begin
          e = qexp[0];
          check("rnd_q", q, e);
          check("rnd_ovf", ovf, (e > MAXV) ? 1 : 0);
          if (out_ready) begin
            void'(qexp.pop_front());
            done_cnt++;
          end
        end
      end
    end
    check("rnd_completed", done_cnt, 1000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
